instr_mem_responder: RTL and testbench

Memory-side responder for the instruction fetch interface monitored by the trace unit: it answers the IF stage's `instr_req`/`instr_addr` with `instr_grant`, then returns `instr_rvalid`/`instr_rdata` after a fixed latency. It holds a word-addressed instruction store that a bench or boot loader preloads through a write port. A stall input and an outstanding-request limit produce realistic grant and response timing for exercising the IF tracker.

---
 rtl/instr_mem_responder_pkg.sv | 13 +
 rtl/instr_mem_responder_delay.sv | 44 ++++
 rtl/instr_mem_responder.sv | 97 +++++++++
 tb/tb_instr_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_responder_pkg.sv
// Shared types for the instruction fetch responder: the response word that
// travels down the delay line and the latency ceiling it is sized against.
package ryuki_datatypes;

    localparam int unsigned INSTR_DATA_WIDTH  = 32;
    localparam int unsigned INSTR_MAX_LATENCY = 8;

    typedef struct packed {
        logic [INSTR_DATA_WIDTH-1:0] rdata;
        logic                        err;
    } instr_resp_t;

endpackage

// File: rtl/instr_mem_responder_delay.sv
// Fixed-latency response pipe. Each stage carries a valid bit plus a response;
// a stage's payload only moves when its input is valid, so the last stage holds
// the most recent response while rvalid is low.
module resp_delay_line
    import ryuki_datatypes::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  instr_resp_t in_resp,
    output logic        out_valid,
    output instr_resp_t out_resp
);

    logic [DEPTH-1:0] valid_q;
    instr_resp_t      resp_q [DEPTH];

    // Shift valid every edge; shift payload only behind a valid entry.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                resp_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) begin
                resp_q[0] <= in_resp;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) begin
                    resp_q[i] <= resp_q[i-1];
                end
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_resp  = resp_q[DEPTH-1];

endmodule

// File: rtl/instr_mem_responder.sv
// Memory-side responder for the IF stage: grants fetches subject to a stall
// input and an outstanding limit, reads a preloadable word store at the accept
// edge and returns the word after a fixed latency, strictly in order.
module instr_mem_responder
    import ryuki_datatypes::*;
#(
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned MEM_DEPTH       = 1024,
    parameter int unsigned RVALID_LATENCY  = 2,
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         instr_req,
    input  logic [ADDR_WIDTH-1:0]        instr_addr,
    output logic                         instr_grant,
    output logic                         instr_rvalid,
    output logic [DATA_WIDTH-1:0]        instr_rdata,
    output logic                         instr_err,
    input  logic                         stall_i,
    input  logic                         load_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] load_addr,
    input  logic [DATA_WIDTH-1:0]        load_data
);

    localparam int unsigned IdxW = $clog2(MEM_DEPTH);
    localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic [IdxW-1:0] rd_idx;
    logic            in_range;
    logic            accept;
    logic            retire;
    logic [CntW-1:0] cnt_q;
    instr_resp_t     rd_resp;
    instr_resp_t     dl_resp;
    logic            dl_valid;
    logic            unused_addr;

    // Byte offset within the word is irrelevant for word fetches.
    assign unused_addr = ^instr_addr[1:0];

    assign rd_idx   = instr_addr[2 +: IdxW];
    assign in_range = (instr_addr[ADDR_WIDTH-1:IdxW+2] == '0);

    // Read the store combinationally so the word captured at the accept edge
    // is the pre-write value when a load hits the same index on that edge.
    always_comb begin
        rd_resp       = '0;
        rd_resp.err   = !in_range;
        if (in_range) begin
            rd_resp.rdata = INSTR_DATA_WIDTH'(mem[rd_idx]);
        end
    end

    // A retiring response frees its slot in the same cycle.
    assign retire      = dl_valid;
    assign instr_grant = instr_req && rst && !stall_i &&
                         ((cnt_q < CntW'(MAX_OUTSTANDING)) || retire);
    assign accept      = instr_req && instr_grant;

    // Track requests accepted but not yet answered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else if (accept && !retire) begin
            cnt_q <= cnt_q + CntW'(1);
        end else if (!accept && retire && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    // Preload port; the store deliberately survives reset.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    resp_delay_line #(
        .DEPTH (RVALID_LATENCY)
    ) u_delay (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (accept),
        .in_resp   (rd_resp),
        .out_valid (dl_valid),
        .out_resp  (dl_resp)
    );

    assign instr_rvalid = dl_valid;
    assign instr_rdata  = DATA_WIDTH'(dl_resp.rdata);
    assign instr_err    = dl_resp.err;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench: a default-parameter responder (latency 2, limit 2) and a
// latency-4 instance for the outstanding-limit and in-flight reset scenarios.
module tb_instr_mem_responder;

    logic        clk = 1'b0;
    logic        rst, rst4;
    logic        req, req4;
    logic [31:0] addr, addr4;
    logic        stall, stall4;
    logic        load_en;
    logic [9:0]  load_addr;
    logic [31:0] load_data;

    logic        grant, rvalid, err;
    logic [31:0] rdata;
    logic        grant4, rvalid4, err4;
    logic [31:0] rdata4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    instr_mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .instr_req    (req),
        .instr_addr   (addr),
        .instr_grant  (grant),
        .instr_rvalid (rvalid),
        .instr_rdata  (rdata),
        .instr_err    (err),
        .stall_i      (stall),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data)
    );

    instr_mem_responder #(
        .RVALID_LATENCY  (4),
        .MAX_OUTSTANDING (2)
    ) dut4 (
        .clk          (clk),
        .rst          (rst4),
        .instr_req    (req4),
        .instr_addr   (addr4),
        .instr_grant  (grant4),
        .instr_rvalid (rvalid4),
        .instr_rdata  (rdata4),
        .instr_err    (err4),
        .stall_i      (stall4),
        .load_en      (load_en),
        .load_addr    (load_addr),
        .load_data    (load_data)
    );

    // Inputs change just after the falling edge; checks run 1 time unit later.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load_word(input logic [9:0] idx, input logic [31:0] data);
        cyc();
        load_en = 1'b1; load_addr = idx; load_data = data;
        cyc();
        load_en = 1'b0;
    endtask

    task automatic test_reset();
        req = 1'b1; req4 = 1'b1;
        #1;
        total++;
        if (rvalid !== 1'b0 || rdata !== 32'h0 || err !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs got rvalid=%b rdata=%h err=%b want 0/0/0",
                     rvalid, rdata, err);
        end
        total++;
        if (grant !== 1'b0 || grant4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_grant got %b/%b want 0/0", grant, grant4);
        end
        total++;
        if (rvalid4 !== 1'b0) begin
            bad++;
            $display("FAIL reset_rvalid4 got %b want 0", rvalid4);
        end
        req = 1'b0; req4 = 1'b0;
        cyc();
        rst = 1'b1; rst4 = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_data [2];
        exp_data[0] = 32'hDEADBEEF;
        exp_data[1] = 32'h00000013;
        for (int c = 0; c < 5; c++) begin
            cyc();
            req  = (c < 2);
            addr = (c == 1) ? 32'h4 : 32'h0;
            #1;
            if (c < 2) begin
                total++;
                if (grant !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_grant cyc=%0d got %b want 1", c, grant);
                end
            end
            total++;
            if (rvalid !== (c == 2 || c == 3)) begin
                bad++;
                $display("FAIL b2b_rvalid cyc=%0d got %b want %b", c, rvalid, (c == 2 || c == 3));
            end
            if (c == 2 || c == 3) begin
                total++;
                if (rdata !== exp_data[c-2] || err !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b_data cyc=%0d got %h err=%b want %h err=0",
                             c, rdata, err, exp_data[c-2]);
                end
            end
        end
        req = 1'b0;
    endtask

    task automatic test_outstanding_limit();
        logic exp_grant [6];
        exp_grant = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int c = 0; c < 6; c++) begin
            cyc();
            req4 = 1'b1; addr4 = 32'h0;
            #1;
            total++;
            if (grant4 !== exp_grant[c]) begin
                bad++;
                $display("FAIL limit_grant cyc=%0d got %b want %b", c, grant4, exp_grant[c]);
            end
            if (c == 4) begin
                total++;
                if (rvalid4 !== 1'b1 || rdata4 !== 32'hDEADBEEF) begin
                    bad++;
                    $display("FAIL limit_retire got rvalid=%b rdata=%h want 1/deadbeef",
                             rvalid4, rdata4);
                end
            end
        end
        cyc();
        req4 = 1'b0;
        repeat (8) cyc();
    endtask

    task automatic test_stall();
        for (int c = 0; c < 6; c++) begin
            cyc();
            stall = (c < 3);
            req   = (c < 4);
            addr  = 32'h0;
            #1;
            if (c < 4) begin
                total++;
                if (grant !== (c == 3)) begin
                    bad++;
                    $display("FAIL stall_grant cyc=%0d got %b want %b", c, grant, (c == 3));
                end
            end
            total++;
            if (rvalid !== (c == 5)) begin
                bad++;
                $display("FAIL stall_rvalid cyc=%0d got %b want %b", c, rvalid, (c == 5));
            end
            if (c == 5) begin
                total++;
                if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
                    bad++;
                    $display("FAIL stall_data got %h err=%b want deadbeef err=0", rdata, err);
                end
            end
        end
        req = 1'b0; stall = 1'b0;
    endtask

    task automatic test_out_of_range();
        cyc();
        req = 1'b1; addr = 32'h0000_1000;
        #1;
        total++;
        if (grant !== 1'b1) begin
            bad++;
            $display("FAIL oor_grant got %b want 1", grant);
        end
        cyc();
        req = 1'b0;
        cyc();
        #1;
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'h0 || err !== 1'b1) begin
            bad++;
            $display("FAIL oor_resp got rvalid=%b rdata=%h err=%b want 1/0/1", rvalid, rdata, err);
        end
        cyc();
    endtask

    task automatic test_load_collision();
        cyc();
        req = 1'b1; addr = 32'hC;
        load_en = 1'b1; load_addr = 10'd3; load_data = 32'hAAAA5555;
        cyc();
        load_en = 1'b0;
        cyc();
        req = 1'b0;
        #1;
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'h12345678) begin
            bad++;
            $display("FAIL collide_old got rvalid=%b rdata=%h want 1/12345678", rvalid, rdata);
        end
        cyc();
        #1;
        total++;
        if (rvalid !== 1'b1 || rdata !== 32'hAAAA5555) begin
            bad++;
            $display("FAIL collide_new got rvalid=%b rdata=%h want 1/aaaa5555", rvalid, rdata);
        end
        cyc();
    endtask

    task automatic test_reset_inflight();
        // Two accepts on the latency-4 instance, then reset before either returns.
        for (int c = 0; c < 9; c++) begin
            cyc();
            rst4  = (c != 2);
            req4  = (c != 4) && (c < 4);
            addr4 = (c == 3) ? 32'h4 : 32'h0;
            #1;
            if (c == 2 || c == 3) begin
                total++;
                if (grant4 !== (c == 3)) begin
                    bad++;
                    $display("FAIL rstflt_grant cyc=%0d got %b want %b", c, grant4, (c == 3));
                end
            end
            if (c >= 3) begin
                total++;
                if (rvalid4 !== (c == 7)) begin
                    bad++;
                    $display("FAIL rstflt_rvalid cyc=%0d got %b want %b", c, rvalid4, (c == 7));
                end
            end
            if (c == 7) begin
                total++;
                if (rdata4 !== 32'h00000013 || err4 !== 1'b0) begin
                    bad++;
                    $display("FAIL rstflt_data got %h err=%b want 00000013 err=0", rdata4, err4);
                end
            end
        end
        req4 = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rst4 = 1'b0;
        req = 1'b0; req4 = 1'b0;
        addr = '0; addr4 = '0;
        stall = 1'b0; stall4 = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        cyc();
        cyc();
        test_reset();
        load_word(10'd0, 32'hDEADBEEF);
        load_word(10'd1, 32'h00000013);
        load_word(10'd3, 32'h12345678);
        test_back_to_back();
        test_outstanding_limit();
        test_stall();
        test_out_of_range();
        test_load_collision();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
